// File: rtl/cdb_writeback.sv
// Result writeback stage: one result buffer per functional unit, round-robin pick
// onto the common data bus, and register file / reg_status writeback on tag match.
module cdb_writeback #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 3,
    parameter int NUM_FU    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             fu_valid,
    output logic [NUM_FU-1:0]             fu_ready,
    input  logic [NUM_FU*REG_INDEX-1:0]   fu_dest,
    input  logic [NUM_FU*WORD_SIZE-1:0]   fu_data,
    output logic [REG_INDEX-1:0]          query_num,
    input  logic [FU_INDEX-1:0]           query_status,
    input  logic                          issue_rs_enable,
    output logic                          cdb_valid,
    output logic [FU_INDEX-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [REG_INDEX-1:0]          write_reg_src,
    output logic [WORD_SIZE-1:0]          write_reg_data,
    output logic                          write_reg_enable,
    output logic [REG_INDEX-1:0]          write_rs_src,
    output logic [FU_INDEX-1:0]           write_rs_status,
    output logic                          write_rs_enable
);

    localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    slot_valid;
    logic [REG_INDEX-1:0] slot_dest [NUM_FU];
    logic [WORD_SIZE-1:0] slot_data [NUM_FU];
    logic [RR_W-1:0]      rr;

    logic                 found;
    logic [RR_W-1:0]      gidx;
    logic [NUM_FU-1:0]    grant;
    logic [FU_INDEX-1:0]  cur_tag;
    logic                 match;

    // Two passes give the rotating priority: first rr..NUM_FU-1, then 0..rr-1.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        if (!reset && !issue_rs_enable) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!found && slot_valid[i] && (RR_W'(i) >= rr)) begin
                    found = 1'b1;
                    gidx  = RR_W'(i);
                end
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (!found && slot_valid[i]) begin
                    found = 1'b1;
                    gidx  = RR_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant            = '0;
        cur_tag          = FU_INDEX'(gidx) + FU_INDEX'(1);
        match            = 1'b0;
        cdb_valid        = 1'b0;
        cdb_tag          = '0;
        cdb_data         = '0;
        query_num        = '0;
        write_reg_src    = '0;
        write_reg_data   = '0;
        write_reg_enable = 1'b0;
        write_rs_src     = '0;
        write_rs_status  = '0;
        write_rs_enable  = 1'b0;
        if (found) begin
            grant[gidx]      = 1'b1;
            cdb_valid        = 1'b1;
            cdb_tag          = cur_tag;
            cdb_data         = slot_data[gidx];
            query_num        = slot_dest[gidx];
            // A different status means the register was renamed to a newer producer.
            match            = (query_status == cur_tag);
            write_reg_enable = match;
            write_rs_enable  = match;
            write_reg_src    = slot_dest[gidx];
            write_reg_data   = slot_data[gidx];
            write_rs_src     = slot_dest[gidx];
        end
        fu_ready = reset ? '1 : (~slot_valid | grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            rr         <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i])
                    slot_valid[i] <= 1'b1;
                else if (grant[i])
                    slot_valid[i] <= 1'b0;
            end
            if (found)
                rr <= (gidx == RR_W'(NUM_FU - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (!reset && fu_valid[i] && fu_ready[i]) begin
                slot_dest[i] <= fu_dest[i*REG_INDEX +: REG_INDEX];
                slot_data[i] <= fu_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule
